// File: rtl/memory_game_sequencer.sv
// Round controller for the melody-memory game: plays the target melody, checks
// the player's presses, pulses success/fail into the jingle player and sequences levels.
module memory_game_sequencer #(
    parameter int unsigned TICK_DIV      = 5_000_000,
    parameter int unsigned NOTE_TICKS    = 2,
    parameter int unsigned GAP_TICKS     = 1,
    parameter int unsigned TIMEOUT_TICKS = 20,
    parameter int unsigned JINGLE_TICKS  = 12,
    parameter int unsigned START_LEN     = 3,
    parameter int unsigned MAX_LEN       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] keys,
    output logic [3:0] note_out,
    output logic [3:0] led_out,
    output logic       success,
    output logic       fail,
    output logic       jingle_active,
    output logic [2:0] level,
    output logic       won
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned T_A   = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int unsigned T_B   = (TIMEOUT_TICKS > JINGLE_TICKS) ? TIMEOUT_TICKS : JINGLE_TICKS;
    localparam int unsigned T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int unsigned TW    = $clog2(T_MAX + 1);

    localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(TICK_DIV - 1);
    localparam logic [TW-1:0]    NOTE_LAST    = TW'(NOTE_TICKS - 1);
    localparam logic [TW-1:0]    GAP_LAST     = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [TW-1:0]    JINGLE_LAST  = TW'(JINGLE_TICKS - 1);
    localparam logic [2:0]       START_IDX    = 3'(START_LEN - 1);
    localparam logic [2:0]       MAX_IDX      = 3'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY_ON,
        S_PLAY_OFF,
        S_LISTEN,
        S_WAIT_JINGLE,
        S_WIN
    } state_t;

    function automatic logic [3:0] rom_note(input logic [2:0] i);
        case (i)
            3'd0:    rom_note = 4'd1;
            3'd1:    rom_note = 4'd2;
            3'd2:    rom_note = 4'd3;
            3'd3:    rom_note = 4'd1;
            3'd4:    rom_note = 4'd4;
            3'd5:    rom_note = 4'd2;
            3'd6:    rom_note = 4'd3;
            default: rom_note = 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] key_note(input logic [3:0] k);
        case (k)
            4'b0001: key_note = 4'd1;
            4'b0010: key_note = 4'd2;
            4'b0100: key_note = 4'd3;
            4'b1000: key_note = 4'd4;
            default: key_note = 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] note_led(input logic [3:0] n);
        case (n)
            4'd1:    note_led = 4'b0001;
            4'd2:    note_led = 4'b0010;
            4'd3:    note_led = 4'b0100;
            4'd4:    note_led = 4'b1000;
            default: note_led = 4'b0000;
        endcase
    endfunction

    state_t           r_state, w_state_next;
    logic [PRE_W-1:0] r_pre;
    logic [TW-1:0]    r_tcnt;
    logic [2:0]       r_idx, w_idx_next;
    logic [2:0]       r_level, w_level_next;
    logic [3:0]       r_keys;
    logic             r_success, w_success_next;
    logic             r_fail, w_fail_next;
    logic             r_was_fail, w_was_fail_next;
    logic             w_press_restart, w_restart;
    logic             w_tick, w_press, w_key_ok;
    logic [3:0]       w_rom;

    assign w_tick   = (r_pre == PRE_LAST);
    assign w_rom    = rom_note(r_idx);
    // Press = rising edge of "any key down"; keys held on entry stay ignored until released.
    assign w_press  = (r_keys == 4'b0000) && (keys != 4'b0000);
    assign w_key_ok = $onehot(keys) && (key_note(keys) == w_rom);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_level_next    = r_level;
        w_success_next  = 1'b0;
        w_fail_next     = 1'b0;
        w_was_fail_next = r_was_fail;
        w_press_restart = 1'b0;
        note_out        = '0;
        led_out         = '0;
        jingle_active   = 1'b0;
        won             = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_PLAY_ON;
                    w_idx_next   = '0;
                end
            end
            S_PLAY_ON: begin
                note_out = w_rom;
                led_out  = note_led(w_rom);
                if (w_tick && r_tcnt == NOTE_LAST) w_state_next = S_PLAY_OFF;
            end
            S_PLAY_OFF: begin
                if (w_tick && r_tcnt == GAP_LAST) begin
                    if (r_idx == r_level) begin
                        w_state_next = S_LISTEN;
                        w_idx_next   = '0;
                    end else begin
                        w_state_next = S_PLAY_ON;
                        w_idx_next   = r_idx + 3'd1;
                    end
                end
            end
            S_LISTEN: begin
                if ($onehot(r_keys)) begin
                    note_out = key_note(r_keys);
                    led_out  = r_keys;
                end
                if (w_press) begin
                    if (w_key_ok && r_idx != r_level) begin
                        w_idx_next      = r_idx + 3'd1;
                        w_press_restart = 1'b1;
                    end else begin
                        w_state_next    = S_WAIT_JINGLE;
                        w_success_next  = w_key_ok;
                        w_fail_next     = !w_key_ok;
                        w_was_fail_next = !w_key_ok;
                    end
                end else if (w_tick && r_tcnt == TIMEOUT_LAST) begin
                    w_state_next    = S_WAIT_JINGLE;
                    w_fail_next     = 1'b1;
                    w_was_fail_next = 1'b1;
                end
            end
            S_WAIT_JINGLE: begin
                jingle_active = 1'b1;
                if (w_tick && r_tcnt == JINGLE_LAST) begin
                    w_idx_next = '0;
                    if (r_was_fail) begin
                        w_state_next = S_PLAY_ON;
                    end else if (r_level == MAX_IDX) begin
                        w_state_next = S_WIN;
                    end else begin
                        w_state_next = S_PLAY_ON;
                        w_level_next = r_level + 3'd1;
                    end
                end
            end
            S_WIN: begin
                led_out = 4'hF;
                won     = 1'b1;
                if (start) begin
                    w_state_next = S_PLAY_ON;
                    w_idx_next   = '0;
                    w_level_next = START_IDX;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        w_restart = w_press_restart || (w_state_next != r_state);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre      <= '0;
            r_tcnt     <= '0;
            r_idx      <= '0;
            r_level    <= START_IDX;
            r_keys     <= '0;
            r_success  <= 1'b0;
            r_fail     <= 1'b0;
            r_was_fail <= 1'b0;
        end else begin
            r_keys     <= keys;
            r_idx      <= w_idx_next;
            r_level    <= w_level_next;
            r_success  <= w_success_next;
            r_fail     <= w_fail_next;
            r_was_fail <= w_was_fail_next;
            if (w_restart) begin
                r_pre  <= '0;
                r_tcnt <= '0;
            end else if (w_tick) begin
                r_pre  <= '0;
                r_tcnt <= r_tcnt + 1'b1;
            end else begin
                r_pre  <= r_pre + 1'b1;
            end
        end
    end

    assign success = r_success;
    assign fail    = r_fail;
    assign level   = r_level;

endmodule

// File: tb/tb_memory_game_sequencer.sv
// Scoreboard bench for memory_game_sequencer with TICK_DIV=4: expected notes and
// pulses are queued as stimulus is driven and compared by a negedge monitor.
module tb_memory_game_sequencer;

    localparam int unsigned TD = 4;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [3:0] keys;
    logic [3:0] note_out, led_out;
    logic       success, fail, jingle_active, won;
    logic [2:0] level;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    memory_game_sequencer #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .start(start), .keys(keys),
        .note_out(note_out), .led_out(led_out), .success(success), .fail(fail),
        .jingle_active(jingle_active), .level(level), .won(won)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        int note;
        int dur;
        int gap;   // -1: preceding silence not constrained
    } note_t;

    note_t nq[$];
    int    pq[$];  // 1 = success, 2 = fail
    int    rom[8] = '{1, 2, 3, 1, 4, 2, 3, 4};

    // Monitor: note runs, pulses and jingle window, all sampled on the falling edge.
    int    run_note = 0, run_len = 0, gap_len = 0, jlen = 0, pulse_cyc = 0, kind;
    logic  prev_pulse = 1'b0;
    note_t e_m;

    always @(negedge clk) begin
        if (note_out != 4'd0) begin
            if (run_len == 0) begin
                run_note = int'(note_out);
                check("onset_led", 32'(led_out), 32'(1) << (run_note - 1));
            end
            run_len++;
        end else begin
            if (run_len != 0) begin
                if (nq.size() == 0) begin
                    check("unexp_note", run_note, 0);
                end else begin
                    e_m = nq.pop_front();
                    check("note_val", run_note, e_m.note);
                    check("note_dur", run_len, e_m.dur);
                    if (e_m.gap >= 0) check("note_gap", gap_len, e_m.gap);
                end
                run_len = 0;
                gap_len = 0;
            end
            gap_len++;
        end

        if (success || fail) begin
            check("pulse_excl", 32'(success & fail), 0);
            check("pulse_single", 32'(prev_pulse), 0);
            check("pulse_jingle", 32'(jingle_active), 1);
            kind = success ? 1 : 2;
            if (pq.size() == 0) check("unexp_pulse", kind, 0);
            else                check("pulse_kind", kind, pq.pop_front());
            pulse_cyc = cyc;
        end
        prev_pulse = success | fail;

        if (jingle_active) jlen++;
        else if (jlen != 0) begin
            check("jingle_len", jlen, 12 * TD);
            jlen = 0;
        end
    end

    int start_cyc = 0;

    task automatic push_note(input int n, input int d, input int g);
        note_t t;
        t.note = n; t.dur = d; t.gap = g;
        nq.push_back(t);
    endtask

    task automatic push_melody(input int n);
        for (int i = 0; i < n; i++) push_note(rom[i], 2 * TD, (i == 0) ? -1 : TD);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((nq.size() != 0 || pq.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain", nq.size() + pq.size(), 0);
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        start_cyc = cyc;
        check("start_lat", 32'(note_out), 1);
    endtask

    task automatic press(input logic [3:0] k, input int hold);
        @(negedge clk); keys = k;
        repeat (hold) @(negedge clk);
        keys = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic fail_round(input logic [3:0] k, input int lvl);
        repeat (6) @(negedge clk);
        pq.push_back(2);
        push_melody(lvl + 1);
        press(k, 3);
        wait_drain(2000);
        check("level_after_fail", 32'(level), lvl);
    endtask

    task automatic success_round(input int lvl);
        repeat (6) @(negedge clk);
        for (int i = 0; i < lvl; i++) push_note(rom[i], 3, -1);
        pq.push_back(1);
        if (lvl < 7) push_melody(lvl + 2);
        for (int i = 0; i <= lvl; i++) press(4'(1 << (rom[i] - 1)), 3);
        wait_drain(3000);
        if (lvl < 7) check("level_after_success", 32'(level), lvl + 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; keys = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_note", 32'(note_out), 0);
        check("rst_led", 32'(led_out), 0);
        check("rst_pulses", 32'({success, fail}), 0);
        check("rst_jingle", 32'(jingle_active), 0);
        check("rst_won", 32'(won), 0);
        check("rst_level", 32'(level), 2);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Timeout round: 36 cycles of melody then 80 silent cycles in LISTEN.
        push_melody(3);
        pq.push_back(2);
        push_melody(3);
        do_start();
        wait_drain(2000);
        check("timeout_cyc", pulse_cyc - start_cyc, 36 + 20 * TD);
        check("level_after_timeout", 32'(level), 2);

        fail_round(4'b0100, 2);
        fail_round(4'b0011, 2);

        for (int l = 2; l <= 7; l++) success_round(l);

        begin
            int k = 0;
            while (!won && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        check("win_cyc", cyc - pulse_cyc, 12 * TD);
        check("win_won", 32'(won), 1);
        check("win_led", 32'(led_out), 15);
        check("win_note", 32'(note_out), 0);
        check("win_level", 32'(level), 7);

        push_note(1, 2 * TD, -1);
        push_note(2, 3, TD);
        do_start();
        check("restart_level", 32'(level), 2);
        check("restart_won", 32'(won), 0);

        begin
            int k = 0;
            while (note_out != 4'd2 && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        check("note2_seen", 32'(note_out), 2);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_note", 32'(note_out), 0);
        check("abort_led", 32'(led_out), 0);
        check("abort_jingle", 32'(jingle_active), 0);
        check("abort_won", 32'(won), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_note", 32'(note_out), 0);
        check("idle_queue", nq.size(), 0);

        push_melody(3);
        do_start();
        wait_drain(500);
        check("resume_level", 32'(level), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_game_sequencer.md
# memory_game_sequencer

Round controller for the melody-memory game. It plays the target melody on the piezo/LED path, checks the player's key presses against it, and fires single-cycle `success`/`fail` pulses into the jingle player. It then waits out the jingle, and either replays at the same length or advances to a longer melody. It sits between the debounced key inputs and the top-level piezo/LED mux; the jingle player owns the outputs while `jingle_active` is high.

## Interface
- `TICK_DIV`, 5_000_000: clk cycles per beat tick.
- `NOTE_TICKS`, 2: ticks a melody note sounds.
- `GAP_TICKS`, 1: silent ticks after each melody note.
- `TIMEOUT_TICKS`, 20: ticks without a press in LISTEN before a fail.
- `JINGLE_TICKS`, 12: ticks reserved for the jingle player after a pulse.
- `START_LEN`, 3: melody length at reset (notes).
- `MAX_LEN`, 8: final melody length; must be ≤ 8.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle start request; honoured only in IDLE or WIN.
- `keys`  in  4  debounced, synchronised buttons; bit k means note k+1.
- `note_out`  out  4  note code to the piezo driver; 0 means silent.
- `led_out`  out  4  LED pattern.
- `success`  out  1  one-cycle pulse to the jingle player.
- `fail`  out  1  one-cycle pulse to the jingle player.
- `jingle_active`  out  1  high in WAIT_JINGLE; the top-level mux selects the jingle player.
- `level`  out  3  current last index (melody length − 1).
- `won`  out  1  high in WIN.

## Operation
- Melody ROM, index 0..7: 1,2,3,1,4,2,3,4. The round uses indices 0..`level`.
- Timebase: a prescaler and an in-state tick counter, both cleared on every state transition. A tick fires when the prescaler reaches `TICK_DIV`−1. State durations are therefore exact multiples of `TICK_DIV`.
- States:
  - IDLE: all outputs 0. `start` → PLAY_ON with idx=0.
  - PLAY_ON: `note_out`=ROM[idx]; `led_out`=one-hot(ROM[idx]−1). After `NOTE_TICKS` ticks → PLAY_OFF.
  - PLAY_OFF: outputs 0. After `GAP_TICKS` ticks:
    - if idx==`level` → LISTEN with idx=0;
    - else idx+1 → PLAY_ON.
  - LISTEN: a press event is the registered `keys` == 0 while the current `keys` ≠ 0.
    - Exactly one bit set and note == ROM[idx]:
      - if idx==`level` → assert `success` and go to WAIT_JINGLE;
      - else idx+1 and stay in LISTEN. The timeout count restarts on every press.
    - Wrong note, or more than one bit set → assert `fail` and go to WAIT_JINGLE.
    - `TIMEOUT_TICKS` ticks with no press → assert `fail` and go to WAIT_JINGLE.
    - Echo: while exactly one key is held, `note_out`=that note and `led_out`=`keys`; otherwise both are 0.
  - WAIT_JINGLE: `note_out`/`led_out` = 0 and `jingle_active`=1. After `JINGLE_TICKS` ticks:
    - after a fail → PLAY_ON with idx=0; `level` unchanged;
    - after a success with `level`==`MAX_LEN`−1 → WIN;
    - after any other success → `level`+1, then PLAY_ON with idx=0.
  - WIN: `led_out`=4'hF, `note_out`=0, `won`=1. `start` → `level`=`START_LEN`−1, then PLAY_ON.
- `start` in any other state is ignored.
- Keys already held when LISTEN is entered are ignored until all keys are released.
- `success` and `fail` are never high together.

## Timing
- Reset values: state IDLE; `note_out`, `led_out`, `success`, `fail`, `jingle_active`, `won` all 0; `level`=`START_LEN`−1 (2); idx 0.
- Reset mid-round aborts immediately. Outputs are forced to their reset values asynchronously.
- `start` sampled at edge N → PLAY_ON outputs are visible from cycle N+1.
- A press first seen at edge N → `success`/`fail` is high for cycle N+1 only. `jingle_active` rises in the same cycle N+1.
- Per-note period = (`NOTE_TICKS`+`GAP_TICKS`)·`TICK_DIV` cycles.
- The echo outputs are registered: one-cycle latency from `keys`.

## Test plan
All scenarios use `TICK_DIV`=4, defaults otherwise.
- Reset, then `start` → `note_out` sequence 1,2,3, each note 8 cycles on and 4 cycles off. LISTEN is entered 36 cycles after `start`. `level`=2.
- In LISTEN, press keys 0001, 0010, 0100 with releases between → a single `success` pulse one cycle after the third press. `jingle_active` lasts 48 cycles, then `level`=3 and a 4-note replay (1,2,3,1).
- In LISTEN, first press is 0100 → `fail` pulse; after 48 cycles the same 3-note melody replays and `level` stays 2.
- In LISTEN, no press for 80 cycles → `fail`. Pressing 0011 → `fail`, with no `note_out` echo.
- Run to `level`=7 and enter all 8 notes → `success`, then WIN with `led_out`=4'hF. Then `start` → `level`=2 and the melody restarts.
- Assert `reset` during PLAY_ON of note 2 → all outputs are 0 immediately, state is IDLE, and `start` is required to resume.
